axis_bram_line_mover: RTL and testbench

//  Parametrised bidirectional AXI-Stream <-> wide-BRAM line mover; successor to the fixed 32b/36-word adapter.

---
 rtl/axis_bram_line_mover.sv | 207 ++++++++++++++++++++
 tb/tb_axis_bram_line_mover.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_bram_line_mover.sv
// ============================================================================
//  Module      : axis_bram_line_mover
//  Description : Bidirectional AXI-Stream <-> wide-BRAM line mover. Write
//                mode packs WORDS stream beats into one BRAM line per address
//                over [start,end]; read mode fetches lines over [start,end]
//                and unpacks them onto the master stream.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module axis_bram_line_mover #(
  parameter int AXIS_W = 32,
  parameter int WORDS  = 36,
  parameter int ADDR_W = 12,
  parameter int RD_LAT = 1
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cfg_rw,
  input  logic                     cfg_reload,
  input  logic [ADDR_W-1:0]        cfg_start_addr,
  input  logic [ADDR_W-1:0]        cfg_end_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     err_range,
  output logic [ADDR_W:0]          line_count,
  input  logic [AXIS_W-1:0]        s_axis_tdata,
  input  logic                     s_axis_tvalid,
  input  logic                     s_axis_tlast,
  output logic                     s_axis_tready,
  output logic [AXIS_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tvalid,
  output logic                     m_axis_tlast,
  input  logic                     m_axis_tready,
  output logic                     bram_en,
  output logic                     bram_we,
  output logic [ADDR_W-1:0]        bram_addr,
  output logic [AXIS_W*WORDS-1:0]  bram_din,
  input  logic [AXIS_W*WORDS-1:0]  bram_dout
);

  localparam int BRAM_W = AXIS_W * WORDS;
  localparam int CNT_W  = $clog2(WORDS + 1);
  localparam int LAT_W  = $clog2(RD_LAT + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_FILL   = 3'd1,
    S_WR_COMMIT = 3'd2,
    S_RD_ISSUE  = 3'd3,
    S_RD_WAIT   = 3'd4,
    S_RD_DRAIN  = 3'd5,
    S_FIN       = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] end_q, end_d;
  logic [BRAM_W-1:0] line_q, line_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;      // word index: fill position or drain position
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              last_q, last_d;    // tlast accepted for the line being filled
  logic [ADDR_W:0]   lcnt_q, lcnt_d;
  logic              err_q, err_d;

  logic w_last_word;
  logic w_at_end;

  assign w_last_word = (cnt_q == CNT_W'(WORDS - 1));
  assign w_at_end    = (addr_q == end_q);

  // State and datapath registers; reset abandons any partial line.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      last_q  <= 1'b0;
      lcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      end_q   <= end_d;
      line_q  <= line_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      last_q  <= last_d;
      lcnt_q  <= lcnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: packing, commit, fetch and unpack sequencing.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    end_d   = end_q;
    line_d  = line_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    last_d  = last_q;
    lcnt_d  = lcnt_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_reload) begin
          lcnt_d = '0;
          err_d  = 1'b0;
          addr_d = cfg_start_addr;
          end_d  = cfg_end_addr;
          cnt_d  = '0;
          last_d = 1'b0;
          line_d = '0;
          if (cfg_end_addr < cfg_start_addr) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = cfg_rw ? S_WR_FILL : S_RD_ISSUE;
          end
        end
      end
      S_WR_FILL: begin
        if (s_axis_tvalid) begin
          line_d[int'(cnt_q)*AXIS_W +: AXIS_W] = s_axis_tdata;
          cnt_d = cnt_q + 1'b1;
          if (w_last_word || s_axis_tlast) begin
            last_d  = s_axis_tlast;
            state_d = S_WR_COMMIT;
          end
        end
      end
      S_WR_COMMIT: begin
        lcnt_d = lcnt_q + 1'b1;
        line_d = '0;
        cnt_d  = '0;
        if (last_q || w_at_end) begin
          state_d = S_FIN;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_WR_FILL;
        end
      end
      S_RD_ISSUE: begin
        lat_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_W'(RD_LAT - 1)) begin
          line_d  = bram_dout;
          cnt_d   = '0;
          state_d = S_RD_DRAIN;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_RD_DRAIN: begin
        if (m_axis_tready) begin
          if (w_last_word) begin
            cnt_d  = '0;
            lcnt_d = lcnt_q + 1'b1;
            if (w_at_end) begin
              state_d = S_FIN;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = S_RD_ISSUE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state; BRAM strobes are held off during reset.
  always_comb begin
    busy          = (state_q != S_IDLE) && (state_q != S_FIN);
    done          = (state_q == S_FIN);
    err_range     = err_q;
    line_count    = lcnt_q;
    s_axis_tready = (state_q == S_WR_FILL);
    m_axis_tvalid = (state_q == S_RD_DRAIN);
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    if (state_q == S_RD_DRAIN) begin
      m_axis_tdata = line_q[int'(cnt_q)*AXIS_W +: AXIS_W];
      m_axis_tlast = w_last_word && w_at_end;
    end
    bram_en   = ((state_q == S_WR_COMMIT) || (state_q == S_RD_ISSUE)) && !areset;
    bram_we   = (state_q == S_WR_COMMIT) && !areset;
    bram_addr = addr_q;
    bram_din  = (state_q == S_WR_COMMIT) ? line_q : '0;
  end

endmodule

`default_nettype wire

// File: tb/tb_axis_bram_line_mover.sv
// ============================================================================
//  Module      : tb_axis_bram_line_mover
//  Description : Directed self-checking bench; instance 0 uses default
//                parameters, instance 1 uses WORDS=4, RD_LAT=2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axis_bram_line_mover;

  logic clk = 1'b0;
  logic areset;
  logic [1:0]        cfg_rw, cfg_reload, s_tvalid, s_tlast, m_tready;
  logic [1:0][11:0]  cfg_start, cfg_end;
  logic [1:0][31:0]  s_tdata;
  wire  [1:0]        busy, done, err, s_tready, m_tvalid, m_tlast, en, we;
  wire  [1:0][12:0]  lc;
  wire  [1:0][31:0]  m_tdata;
  wire  [1:0][11:0]  baddr;
  wire  [1151:0]     dinA;
  wire  [127:0]      dinB;
  logic [1151:0]     pA0;
  logic [127:0]      pB0, pB1;

  logic [1151:0] memA [16];
  logic [127:0]  memB [16];
  int wr_cnt [2];
  int en_cnt [2];
  int done_cnt [2];
  int wr_at [16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  axis_bram_line_mover u_dut_a (
    .aclk(clk), .areset(areset),
    .cfg_rw(cfg_rw[0]), .cfg_reload(cfg_reload[0]),
    .cfg_start_addr(cfg_start[0]), .cfg_end_addr(cfg_end[0]),
    .busy(busy[0]), .done(done[0]), .err_range(err[0]), .line_count(lc[0]),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]),
    .s_axis_tlast(s_tlast[0]), .s_axis_tready(s_tready[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]),
    .m_axis_tlast(m_tlast[0]), .m_axis_tready(m_tready[0]),
    .bram_en(en[0]), .bram_we(we[0]), .bram_addr(baddr[0]),
    .bram_din(dinA), .bram_dout(pA0)
  );

  axis_bram_line_mover #(.AXIS_W(32), .WORDS(4), .ADDR_W(12), .RD_LAT(2)) u_dut_b (
    .aclk(clk), .areset(areset),
    .cfg_rw(cfg_rw[1]), .cfg_reload(cfg_reload[1]),
    .cfg_start_addr(cfg_start[1]), .cfg_end_addr(cfg_end[1]),
    .busy(busy[1]), .done(done[1]), .err_range(err[1]), .line_count(lc[1]),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]),
    .s_axis_tlast(s_tlast[1]), .s_axis_tready(s_tready[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]),
    .m_axis_tlast(m_tlast[1]), .m_axis_tready(m_tready[1]),
    .bram_en(en[1]), .bram_we(we[1]), .bram_addr(baddr[1]),
    .bram_din(dinB), .bram_dout(pB1)
  );

  // BRAM models: A has 1-cycle read latency, B has an extra output register.
  always @(posedge clk) begin
    if (en[0]) begin
      en_cnt[0] <= en_cnt[0] + 1;
      if (we[0]) begin
        memA[baddr[0][3:0]]  <= dinA;
        wr_cnt[0]            <= wr_cnt[0] + 1;
        wr_at[baddr[0][3:0]] <= wr_at[baddr[0][3:0]] + 1;
      end else begin
        pA0 <= memA[baddr[0][3:0]];
      end
    end
    if (en[1]) begin
      en_cnt[1] <= en_cnt[1] + 1;
      if (we[1]) begin
        memB[baddr[1][3:0]] <= dinB;
        wr_cnt[1]           <= wr_cnt[1] + 1;
      end else begin
        pB0 <= memB[baddr[1][3:0]];
      end
    end
    pB1 <= pB0;
  end

  // Done pulse counters.
  always @(posedge clk) begin
    if (done[0]) done_cnt[0] <= done_cnt[0] + 1;
    if (done[1]) done_cnt[1] <= done_cnt[1] + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic reload(input int s, input bit rw, input int st, input int en_a);
    @(negedge clk);
    cfg_rw[s]     = rw;
    cfg_start[s]  = 12'(st);
    cfg_end[s]    = 12'(en_a);
    cfg_reload[s] = 1'b1;
    @(negedge clk);
    cfg_reload[s] = 1'b0;
  endtask

  // Offers beats 0..n-1; stops at the first beat not accepted within 40 cycles.
  task automatic send(input int s, input int n, input int last_idx, output int acc);
    int w;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      s_tdata[s]  = 32'(i);
      s_tvalid[s] = 1'b1;
      s_tlast[s]  = (i == last_idx);
      w = 0;
      while (!s_tready[s] && w < 40) begin
        @(negedge clk);
        w++;
      end
      if (!s_tready[s]) break;
      @(negedge clk);
      acc++;
    end
    s_tvalid[s] = 1'b0;
    s_tlast[s]  = 1'b0;
  endtask

  // Expects words 0..n-1 with tlast only on the final one.
  task automatic receive(input int s, input int n, input bit toggle, input string tag);
    bit          held;
    logic [31:0] hd;
    logic        hl;
    int          got, cyc, bl, bs;
    held = 0; got = 0; cyc = 0; bl = 0; bs = 0; hd = '0; hl = 1'b0;
    while (got < n && cyc < 3000) begin
      m_tready[s] = toggle ? (cyc % 2 == 0) : 1'b1;
      if (held && (!m_tvalid[s] || m_tdata[s] !== hd || m_tlast[s] !== hl)) bs++;
      held = 0;
      if (m_tvalid[s]) begin
        if (m_tready[s]) begin
          check_eq({tag, " data"}, 64'(m_tdata[s]), 64'(got));
          if (m_tlast[s] !== (got == n - 1)) bl++;
          got++;
        end else begin
          held = 1;
          hd   = m_tdata[s];
          hl   = m_tlast[s];
        end
      end
      @(negedge clk);
      cyc++;
    end
    m_tready[s] = 1'b0;
    check_eq({tag, " words"}, 64'(got), 64'(n));
    check_eq({tag, " tlast errors"}, 64'(bl), 64'd0);
    check_eq({tag, " stall stability errors"}, 64'(bs), 64'd0);
  endtask

  task automatic wait_idle(input int s, input string tag);
    int w;
    w = 0;
    while (busy[s] && w < 500) begin
      @(negedge clk);
      w++;
    end
    check_eq({tag, " reaches idle"}, 64'(busy[s]), 64'd0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int s, input string tag);
    check_eq({tag, " busy"}, 64'(busy[s]), 64'd0);
    check_eq({tag, " done"}, 64'(done[s]), 64'd0);
    check_eq({tag, " err_range"}, 64'(err[s]), 64'd0);
    check_eq({tag, " line_count"}, 64'(lc[s]), 64'd0);
    check_eq({tag, " s_tready"}, 64'(s_tready[s]), 64'd0);
    check_eq({tag, " m_tvalid"}, 64'(m_tvalid[s]), 64'd0);
    check_eq({tag, " m_tlast"}, 64'(m_tlast[s]), 64'd0);
    check_eq({tag, " m_tdata"}, 64'(m_tdata[s]), 64'd0);
    check_eq({tag, " bram_en"}, 64'(en[s]), 64'd0);
    check_eq({tag, " bram_we"}, 64'(we[s]), 64'd0);
    check_eq({tag, " bram_addr"}, 64'(baddr[s]), 64'd0);
    check_eq({tag, " bram_din zero"}, (s == 0) ? 64'(dinA == '0) : 64'(dinB == '0), 64'd1);
  endtask

  // Number of words in line a that differ from base+k (k<nfill) or 0.
  function automatic int line_bad(input int s, input int a, input int base, input int nfill);
    int          words, b;
    logic [31:0] w, e;
    words = (s == 0) ? 36 : 4;
    b = 0;
    for (int k = 0; k < words; k++) begin
      w = (s == 0) ? memA[a][k*32 +: 32] : memB[a][k*32 +: 32];
      e = (k < nfill) ? 32'(base + k) : 32'd0;
      if (w !== e) b++;
    end
    return b;
  endfunction

  initial begin
    int acc, wr0, en0, dn0, w7;
    areset = 1'b1;
    cfg_rw = '0; cfg_reload = '0; s_tvalid = '0; s_tlast = '0; m_tready = '0;
    cfg_start = '0; cfg_end = '0; s_tdata = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs(0, "reset A");
    check_reset_outputs(1, "reset B");
    areset = 1'b0;

    // T1: two full lines at 0..1
    wr0 = wr_cnt[0]; dn0 = done_cnt[0];
    reload(0, 1'b1, 0, 1);
    send(0, 72, 71, acc);
    check_eq("T1 accepted", 64'(acc), 64'd72);
    wait_idle(0, "T1");
    check_eq("T1 writes", 64'(wr_cnt[0] - wr0), 64'd2);
    check_eq("T1 line_count", 64'(lc[0]), 64'd2);
    check_eq("T1 done pulses", 64'(done_cnt[0] - dn0), 64'd1);
    check_eq("T1 line0 bad words", 64'(line_bad(0, 0, 0, 36)), 64'd0);
    check_eq("T1 line1 bad words", 64'(line_bad(0, 1, 36, 36)), 64'd0);

    // T4: read back with tready toggling
    dn0 = done_cnt[0];
    reload(0, 1'b0, 0, 1);
    receive(0, 72, 1'b1, "T4");
    wait_idle(0, "T4");
    check_eq("T4 line_count", 64'(lc[0]), 64'd2);
    check_eq("T4 done pulses", 64'(done_cnt[0] - dn0), 64'd1);

    // T2: tlast flushes a partial second line
    wr0 = wr_cnt[0];
    w7  = wr_at[7] + wr_at[8] + wr_at[9];
    reload(0, 1'b1, 5, 9);
    send(0, 40, 39, acc);
    check_eq("T2 accepted", 64'(acc), 64'd40);
    wait_idle(0, "T2");
    check_eq("T2 writes", 64'(wr_cnt[0] - wr0), 64'd2);
    check_eq("T2 writes at 7..9", 64'(wr_at[7] + wr_at[8] + wr_at[9] - w7), 64'd0);
    check_eq("T2 line_count", 64'(lc[0]), 64'd2);
    check_eq("T2 line5 bad words", 64'(line_bad(0, 5, 0, 36)), 64'd0);
    check_eq("T2 line6 bad words", 64'(line_bad(0, 6, 36, 4)), 64'd0);

    // T3: region full without tlast leaves surplus beats unaccepted
    wr0 = wr_cnt[0]; dn0 = done_cnt[0];
    reload(0, 1'b1, 0, 0);
    send(0, 50, -1, acc);
    check_eq("T3 accepted", 64'(acc), 64'd36);
    check_eq("T3 tready after region", 64'(s_tready[0]), 64'd0);
    wait_idle(0, "T3");
    check_eq("T3 writes", 64'(wr_cnt[0] - wr0), 64'd1);
    check_eq("T3 line_count", 64'(lc[0]), 64'd1);
    check_eq("T3 done pulses", 64'(done_cnt[0] - dn0), 64'd1);
    check_eq("T3 line0 bad words", 64'(line_bad(0, 0, 0, 36)), 64'd0);

    // T5: range error, then a reload while busy is ignored
    en0 = en_cnt[0];
    reload(0, 1'b1, 8, 3);
    check_eq("T5 done", 64'(done[0]), 64'd1);
    check_eq("T5 err_range", 64'(err[0]), 64'd1);
    check_eq("T5 busy in done cycle", 64'(busy[0]), 64'd0);
    @(negedge clk);
    check_eq("T5 done one cycle", 64'(done[0]), 64'd0);
    check_eq("T5 err sticky", 64'(err[0]), 64'd1);
    check_eq("T5 bram_en count", 64'(en_cnt[0] - en0), 64'd0);
    reload(0, 1'b0, 0, 0);
    check_eq("T5 err cleared", 64'(err[0]), 64'd0);
    repeat (3) @(negedge clk);
    cfg_rw[0] = 1'b1; cfg_start[0] = 12'd8; cfg_end[0] = 12'd3; cfg_reload[0] = 1'b1;
    @(negedge clk);
    cfg_reload[0] = 1'b0;
    check_eq("T5 busy reload ignored err", 64'(err[0]), 64'd0);
    check_eq("T5 still busy", 64'(busy[0]), 64'd1);
    receive(0, 36, 1'b0, "T5 read");
    wait_idle(0, "T5");
    check_eq("T5 line_count", 64'(lc[0]), 64'd1);

    // T6: reset mid-write, then WORDS=4 / RD_LAT=2 instance
    wr0 = wr_cnt[0];
    reload(0, 1'b1, 0, 1);
    send(0, 20, -1, acc);
    check_eq("T6 accepted before reset", 64'(acc), 64'd20);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    check_reset_outputs(0, "T6 after reset");
    repeat (2) @(negedge clk);
    check_eq("T6 aborted writes", 64'(wr_cnt[0] - wr0), 64'd0);

    dn0 = done_cnt[1];
    reload(1, 1'b1, 0, 1);
    send(1, 8, 7, acc);
    check_eq("T6B accepted", 64'(acc), 64'd8);
    wait_idle(1, "T6B write");
    check_eq("T6B writes", 64'(wr_cnt[1]), 64'd2);
    check_eq("T6B line_count", 64'(lc[1]), 64'd2);
    check_eq("T6B done pulses", 64'(done_cnt[1] - dn0), 64'd1);
    check_eq("T6B line0 bad words", 64'(line_bad(1, 0, 0, 4)), 64'd0);
    check_eq("T6B line1 bad words", 64'(line_bad(1, 1, 4, 4)), 64'd0);
    reload(1, 1'b0, 0, 1);
    receive(1, 8, 1'b1, "T6B read");
    wait_idle(1, "T6B read");
    check_eq("T6B read line_count", 64'(lc[1]), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
